// File: rtl/pattern_gen.sv
// -----------------------------------------------------------------------------
// pattern_gen
//   Serial stimulus source. It captures a LEN-bit pattern and a repeat count,
//   then replays the pattern MSB first onto `a`, one bit per clock. The
//   pattern plays repeat_n+1 times back to back with no gap cycles. A one-cycle
//   `done` pulse follows the final bit. All outputs are registered.
//
//   States: IDLE -> SHIFT -> DONE -> IDLE.
//
// Parameters
//   LEN       pattern length in bits (>= 2)
//   CNT_W     width of the repeat count
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   start     in   request playback; sampled only in IDLE
//   hold      in   (PATTERN_GEN_HOLD_EN only) stall playback while high
//   pattern   in   bits to play; captured on the accepting edge
//   repeat_n  in   extra repetitions; captured on the accepting edge
//   a         out  serial output bit; 0 whenever valid=0
//   valid     out  a carries a pattern bit this cycle
//   busy      out  high in SHIFT and DONE
//   done      out  one-cycle pulse after the final bit
//
// Configuration
//   PATTERN_GEN_HOLD_EN  adds the `hold` input. While hold=1 in SHIFT, the
//                        shift register and counters freeze and valid=0. When
//                        hold drops, the frozen bit is emitted with valid=1.
//                        If the macro is undefined, there is no hold port.
// -----------------------------------------------------------------------------
module pattern_gen #(
    parameter int LEN   = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef PATTERN_GEN_HOLD_EN
    input  logic             hold,
`endif
    input  logic [LEN-1:0]   pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             a,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int               BIT_W    = $clog2(LEN);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state,   w_state_nxt;
    logic [LEN-1:0]     r_pat,     w_pat_nxt;      // captured pattern, used for reloads
    logic [LEN-1:0]     r_shift,   w_shift_nxt;    // bits not yet emitted, next bit at MSB
    logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;  // bits still to emit in this pass
    logic [CNT_W-1:0]   r_rep_cnt, w_rep_cnt_nxt;  // passes still to start after this one
    logic               r_a,       w_a_nxt;
    logic               r_valid,   w_valid_nxt;
    logic               r_busy,    w_busy_nxt;
    logic               r_done,    w_done_nxt;
    logic               w_hold;

`ifdef PATTERN_GEN_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    // The output flops hold the bit currently on the line. r_shift already
    // holds the following bit at its MSB. Therefore, a stall only has to skip
    // the advance. The frozen bit then comes out when hold drops.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt   = r_state;
        w_pat_nxt     = r_pat;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_rep_cnt_nxt = r_rep_cnt;
        w_a_nxt       = 1'b0;
        w_valid_nxt   = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_SHIFT;
                    w_pat_nxt     = pattern;
                    w_shift_nxt   = {pattern[LEN-2:0], 1'b0};
                    w_bit_cnt_nxt = LAST_BIT;
                    w_rep_cnt_nxt = repeat_n;
                    w_a_nxt       = pattern[LEN-1];
                    w_valid_nxt   = 1'b1;
                    w_busy_nxt    = 1'b1;
                end
            end

            S_SHIFT: begin
                w_busy_nxt = 1'b1;
                if (!w_hold) begin
                    if (r_bit_cnt != '0) begin
                        w_a_nxt       = r_shift[LEN-1];
                        w_valid_nxt   = 1'b1;
                        w_shift_nxt   = {r_shift[LEN-2:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt - BIT_W'(1);
                    end else if (r_rep_cnt != '0) begin
                        // Start the next pass on the very next cycle, with no gap.
                        w_a_nxt       = r_pat[LEN-1];
                        w_valid_nxt   = 1'b1;
                        w_shift_nxt   = {r_pat[LEN-2:0], 1'b0};
                        w_bit_cnt_nxt = LAST_BIT;
                        w_rep_cnt_nxt = r_rep_cnt - CNT_W'(1);
                    end else begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_rep_cnt <= '0;
            r_a       <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pat     <= w_pat_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_rep_cnt <= w_rep_cnt_nxt;
            r_a       <= w_a_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign a     = r_a;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_pattern_gen
//   Self-checking bench for pattern_gen. A reference model describes the
//   output stream. It tracks the stream position k and the total number of
//   bits LEN*(repeat_n+1). Bit k of the stream is pattern[LEN-1 - k%LEN].
//   Directed scenarios come first, then a randomized run. PATTERN_GEN_HOLD_EN
//   enables the hold scenario.
// -----------------------------------------------------------------------------
module tb_pattern_gen;

    localparam int LEN   = 8;
    localparam int CNT_W = 4;
`ifdef PATTERN_GEN_HOLD_EN
    localparam bit HAS_HOLD = 1'b1;
`else
    localparam bit HAS_HOLD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             hold;
    logic [LEN-1:0]   pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             a, valid, busy, done;

    int total = 0;
    int bad   = 0;

    pattern_gen #(.LEN(LEN), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef PATTERN_GEN_HOLD_EN
        .hold     (hold),
`endif
        .pattern  (pattern),
        .repeat_n (repeat_n),
        .a        (a),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference model state.
    bit             m_active;
    bit             m_in_done;
    int             m_k;
    int             m_total;
    logic [LEN-1:0] m_pat;
    logic           e_a, e_v, e_b, e_d;

    // Observation bookkeeping for the directed scenarios.
    logic [63:0] cap;
    int          ncap, done_cnt, done_at, step_no;
    bit          prev_valid;
    int          rises[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_in_done = 1'b0;
        {e_a, e_v, e_b, e_d} = 4'b0000;
    endtask

    // Expected outputs after the next rising edge, from the current inputs.
    task automatic model_edge();
        bit h;
        h = hold & HAS_HOLD;
        if (reset) begin
            model_reset();
        end else if (m_in_done) begin
            m_in_done = 1'b0;
            {e_a, e_v, e_b, e_d} = 4'b0000;
        end else if (m_active) begin
            if (h) begin
                {e_a, e_v, e_b, e_d} = 4'b0010;
            end else if (m_k < m_total) begin
                e_a = m_pat[LEN-1-(m_k % LEN)];
                {e_v, e_b, e_d} = 3'b110;
                m_k++;
            end else begin
                m_active  = 1'b0;
                m_in_done = 1'b1;
                {e_a, e_v, e_b, e_d} = 4'b0011;
            end
        end else if (start) begin
            m_active = 1'b1;
            m_pat    = pattern;
            m_total  = LEN * (int'(repeat_n) + 1);
            e_a      = pattern[LEN-1];
            {e_v, e_b, e_d} = 3'b110;
            m_k      = 1;
        end else begin
            {e_a, e_v, e_b, e_d} = 4'b0000;
        end
    endtask

    task automatic clear_obs();
        cap        = '0;
        ncap       = 0;
        done_cnt   = 0;
        done_at    = -1;
        step_no    = 0;
        prev_valid = 1'b0;
        rises.delete();
    endtask

    // Drive inputs for one edge, advance the model, and compare on the next
    // falling edge.
    task automatic step(input logic s, input logic [LEN-1:0] p,
                        input logic [CNT_W-1:0] r, input logic h);
        start    = s;
        pattern  = p;
        repeat_n = r;
        hold     = h & HAS_HOLD;
        model_edge();
        @(negedge clk);
        check("a",     a,     e_a);
        check("valid", valid, e_v);
        check("busy",  busy,  e_b);
        check("done",  done,  e_d);
        step_no++;
        if (valid) begin
            cap = {cap[62:0], a};
            ncap++;
            if (!prev_valid) rises.push_back(step_no);
        end
        prev_valid = valid;
        if (done) begin
            done_cnt++;
            done_at = step_no;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, LEN'($urandom), CNT_W'($urandom), 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hold = 1'b0; pattern = '0; repeat_n = '0;
        model_reset();
        @(negedge clk);
        step(1'b0, '0, '0, 1'b0);
        check("rst_state", {a, valid, busy, done}, 4'b0000);
        reset = 1'b0;
        idle_steps(2);

        // 1: reset mid-run clears the outputs asynchronously, with no done pulse afterwards.
        step(1'b1, LEN'($urandom), 4'd3, 1'b0);
        idle_steps(5);
        reset = 1'b1;
        start = 1'b1; pattern = LEN'($urandom); repeat_n = CNT_W'($urandom);
        #1;
        check("rst_async", {a, valid, busy, done}, 4'b0000);
        model_reset();
        clear_obs();
        step(1'b1, LEN'($urandom), CNT_W'($urandom), 1'b0);
        reset = 1'b0;
        idle_steps(6);
        check("rst_no_done", done_cnt, 0);
        check("rst_no_valid", ncap, 0);

        // 2: single pass of 1011_0010.
        clear_obs();
        step(1'b1, 8'b1011_0010, 4'd0, 1'b0);
        idle_steps(9);
        check("t2_bits", cap[7:0], 8'hB2);
        check("t2_nbits", ncap, 8);
        check("t2_done_at", done_at, 9);
        check("t2_busy_end", busy, 0);

        // 3: three passes of 1000_0001.
        clear_obs();
        step(1'b1, 8'b1000_0001, 4'd2, 1'b0);
        idle_steps(27);
        check("t3_bits", cap[23:0], 24'h818181);
        check("t3_nbits", ncap, 24);
        check("t3_runs", rises.size(), 1);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_done_at", done_at, 25);

        // 4: changes to start, pattern, and repeat_n during playback are ignored.
        clear_obs();
        step(1'b1, 8'b1011_0010, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 8'hFF, 4'd5, 1'b0);
        idle_steps(8);
        check("t4_bits", cap[7:0], 8'hB2);
        check("t4_nbits", ncap, 8);
        check("t4_done_cnt", done_cnt, 1);

        // 5: start held high repeats with a 10-cycle period.
        clear_obs();
        for (int i = 0; i < 30; i++) step(1'b1, 8'b1011_0010, 4'd0, 1'b0);
        idle_steps(3);
        check("t5_nbits", ncap, 24);
        check("t5_done_cnt", done_cnt, 3);
        check("t5_runs", rises.size(), 3);
        if (rises.size() >= 3) begin
            check("t5_period1", rises[1] - rises[0], 10);
            check("t5_period2", rises[2] - rises[1], 10);
        end

`ifdef PATTERN_GEN_HOLD_EN
        // 6: hold for 3 cycles after the third bit.
        clear_obs();
        step(1'b1, 8'b1011_0010, 4'd0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
        idle_steps(8);
        check("t6_bits", cap[7:0], 8'hB2);
        check("t6_runs", rises.size(), 2);
        check("t6_done_at", done_at, 12);
`endif

        // Randomized stimulus against the model.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            step(($urandom_range(0, 3) == 0), LEN'($urandom),
                 CNT_W'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
        end
        reset = 1'b0;
        idle_steps(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
